gda_vl_adder: RTL and testbench

Parametrised, pipelined Generic Degradable Adder (GDA) with runtime accuracy control. Adds two N-bit operands by splitting them into BLK-bit sub-adders. Each block's carry-in is predicted from the PRED bits directly below it. The block also detects prediction errors and, in accurate mode, spends one extra cycle delivering the exact sum. It sits in the approximate-adder integration flow as the drop-in successor of the fixed-size GDA variants, adding a valid/ready stream interface and error statistics.

---
 rtl/gda_vl_adder_pkg.sv | 19 +
 rtl/gda_vl_adder_if.sv | 25 ++
 rtl/gda_vl_adder_core.sv | 42 ++++
 rtl/gda_vl_adder.sv | 112 +++++++++++
 tb/tb_gda_vl_adder.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gda_vl_adder_pkg.sv
// Shared types, constants and parameter legality check for the GDA adder.
package gda_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        CORR = 2'd2
    } gda_state_e;

    localparam logic MODE_APPROX   = 1'b0;
    localparam logic MODE_ACCURATE = 1'b1;

    // Operand width and lookback must both be whole numbers of sub-adder blocks.
    function automatic bit params_ok(input int n, input int blk, input int pred);
        return (blk > 0) && (n > 0) && (n % blk == 0) && (pred % blk == 0)
               && (pred > 0) && (pred <= n);
    endfunction

endpackage

// File: rtl/gda_vl_adder_if.sv
// Operand/result stream of the GDA adder with valid/ready on both sides.
interface gda_vl_adder_if #(
    parameter int N = 16
);
    logic         in_valid_i;
    logic         in_ready_o;
    logic [N-1:0] in1_i;
    logic [N-1:0] in2_i;
    logic         mode_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [N:0]   res_o;
    logic         err_o;
    logic         corr_o;

    modport master (
        output in_valid_i, in1_i, in2_i, mode_i, out_ready_i,
        input  in_ready_o, out_valid_o, res_o, err_o, corr_o
    );

    modport slave (
        input  in_valid_i, in1_i, in2_i, mode_i, out_ready_i,
        output in_ready_o, out_valid_o, res_o, err_o, corr_o
    );
endinterface

// File: rtl/gda_vl_adder_core.sv
// Combinational GDA datapath: block-wise approximate sum, exact sum, error flag.
module gda_core #(
    parameter int N    = 16,
    parameter int BLK  = 4,
    parameter int PRED = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N:0]   approx_o,
    output logic [N:0]   exact_o,
    output logic         err_o
);
    localparam int NB = N / BLK;

    logic [N-1:0]  sum_blk;
    logic [NB-1:0] cout;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        localparam int HI = k * BLK;
        localparam int LO = (HI > PRED) ? HI - PRED : 0;
        logic         cin;
        logic [BLK:0] bsum;

        if (k == 0) begin : g_first
            assign cin = 1'b0;
        end else begin : g_pred
            // Carry-in guessed from the PRED bits just below, added with carry-in 0.
            logic [HI-LO:0] psum;
            assign psum = {1'b0, a_i[HI-1:LO]} + {1'b0, b_i[HI-1:LO]};
            assign cin  = psum[HI-LO];
        end

        assign bsum = {1'b0, a_i[HI +: BLK]} + {1'b0, b_i[HI +: BLK]} + {{BLK{1'b0}}, cin};
        assign sum_blk[HI +: BLK] = bsum[BLK-1:0];
        assign cout[k] = bsum[BLK];
    end

    assign approx_o = {cout[NB-1], sum_blk};
    assign exact_o  = {1'b0, a_i} + {1'b0, b_i};
    assign err_o    = (approx_o != exact_o);

endmodule

// File: rtl/gda_vl_adder.sv
// GDA adder top: accept/hold/correct FSM, output registers, error counter.
module gda_vl_adder
    import gda_pkg::*;
#(
    parameter int N     = 16,
    parameter int BLK   = 4,
    parameter int PRED  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    gda_vl_adder_if.slave    bus,
    output logic [CNT_W-1:0] err_cnt_o,
    input  logic             err_clr_i
);
    if (!params_ok(N, BLK, PRED)) begin : g_param_err
        $error("gda_vl_adder: illegal N/BLK/PRED combination");
    end

    gda_state_e       state_q, state_d;
    logic [N:0]       res_q, res_d;
    logic [N:0]       exact_q, exact_d;
    logic             err_q, err_d;
    logic             corr_q, corr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N:0] approx, exact;
    logic       beat_err;
    logic       in_ready;
    logic       accept;

    gda_core #(
        .N    (N),
        .BLK  (BLK),
        .PRED (PRED)
    ) u_core (
        .a_i      (bus.in1_i),
        .b_i      (bus.in2_i),
        .approx_o (approx),
        .exact_o  (exact),
        .err_o    (beat_err)
    );

    assign in_ready = (state_q == IDLE) | ((state_q == HOLD) & bus.out_ready_i);
    assign accept   = bus.in_valid_i & in_ready;

    // Next state and output-register loads for accept, correction and handshake.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        exact_d = exact_q;
        err_d   = err_q;
        corr_d  = corr_q;
        case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    res_d   = approx;
                    exact_d = exact;
                    err_d   = beat_err;
                    corr_d  = 1'b0;
                    state_d = (bus.mode_i == MODE_ACCURATE && beat_err) ? CORR : HOLD;
                end else if (state_q == HOLD && bus.out_ready_i) begin
                    state_d = IDLE;
                end
            end
            CORR: begin
                res_d   = exact_q;
                err_d   = 1'b1;
                corr_d  = 1'b1;
                state_d = HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating error counter; clear takes priority over a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (err_clr_i) begin
            cnt_d = '0;
        end else if (accept && beat_err && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            exact_q <= '0;
            err_q   <= 1'b0;
            corr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            exact_q <= exact_d;
            err_q   <= err_d;
            corr_q  <= corr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = (state_q == HOLD);
    assign bus.res_o       = res_q;
    assign bus.err_o       = err_q;
    assign bus.corr_o      = corr_q;
    assign err_cnt_o       = cnt_q;

endmodule

// File: tb/tb_gda_vl_adder.sv
// Self-checking bench for gda_vl_adder: directed test-plan sequence plus random traffic.
module tb_gda_vl_adder;
    localparam int N     = 16;
    localparam int BLK   = 4;
    localparam int PRED  = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] err_cnt;
    logic             err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    gda_vl_adder_if #(.N(N)) bus ();

    gda_vl_adder #(
        .N     (N),
        .BLK   (BLK),
        .PRED  (PRED),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .err_cnt_o (err_cnt),
        .err_clr_i (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each block adds its slice plus a carry guessed from a PRED-bit window.
    function automatic logic [N:0] m_approx(input logic [N-1:0] a, input logic [N-1:0] b);
        longint unsigned aa, bb, r, hi, lo, cin, s, bm;
        aa = a; bb = b; r = 0; bm = 64'd1 << BLK;
        for (int k = 0; k < N / BLK; k++) begin
            hi = k * BLK;
            lo = (hi > PRED) ? hi - PRED : 0;
            if (k == 0) cin = 0;
            else cin = ((((aa % (64'd1 << hi)) >> lo) + ((bb % (64'd1 << hi)) >> lo)) >> (hi - lo)) & 1;
            s = ((aa >> hi) % bm) + ((bb >> hi) % bm) + cin;
            r = r | ((s % bm) << hi);
            if (k == N / BLK - 1) r = r | ((s / bm) << N);
        end
        return r[N:0];
    endfunction

    function automatic logic [N:0] m_exact(input logic [N-1:0] a, input logic [N-1:0] b);
        longint unsigned s;
        s = longint'(a) + longint'(b);
        return s[N:0];
    endfunction

    // Model of the stream: one beat in flight, with its remaining latency before visibility.
    bit         m_busy = 0;
    int         m_wait = 0;
    logic [N:0] m_res  = '0;
    bit         m_err  = 0;
    bit         m_corr = 0;
    int         m_cnt  = 0;

    always @(posedge clk or negedge rst_n) begin
        bit rdy, acc, e;
        logic [N:0] ap, ex;
        if (!rst_n) begin
            m_busy = 0; m_wait = 0; m_cnt = 0;
        end else begin
            rdy = !m_busy || (m_wait == 0 && bus.out_ready_i);
            acc = bus.in_valid_i && rdy;
            ap  = m_approx(bus.in1_i, bus.in2_i);
            ex  = m_exact(bus.in1_i, bus.in2_i);
            e   = (ap != ex);
            if (m_busy && m_wait > 0) m_wait--;
            else if (m_busy && bus.out_ready_i) m_busy = 0;
            if (acc) begin
                m_busy = 1;
                if (bus.mode_i && e) begin
                    m_wait = 1; m_res = ex; m_err = 1; m_corr = 1;
                end else begin
                    m_wait = 0; m_res = ap; m_err = e; m_corr = 0;
                end
            end
            if (err_clr) m_cnt = 0;
            else if (acc && e && m_cnt < CMAX) m_cnt++;
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", bus.out_valid_o, (m_busy && m_wait == 0));
            chk("in_ready", bus.in_ready_o, (!m_busy || (m_wait == 0 && bus.out_ready_i)));
            chk("err_cnt", err_cnt, m_cnt);
            if (m_busy && m_wait == 0) begin
                chk("res", bus.res_o, m_res);
                chk("err", bus.err_o, m_err);
                chk("corr", bus.corr_o, m_corr);
            end
        end
    end

    task automatic step(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic m, input logic ordy, input logic clr);
        @(negedge clk);
        #2;
        bus.in_valid_i  = v;
        bus.in1_i       = a;
        bus.in2_i       = b;
        bus.mode_i      = m;
        bus.out_ready_i = ordy;
        err_clr         = clr;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        int n_out;
        logic [N-1:0] ra, rb;
        bus.in_valid_i = 0; bus.in1_i = '0; bus.in2_i = '0; bus.mode_i = 0; bus.out_ready_i = 1;

        // Hand-computed pins on the reference model.
        chk("pin_ap_1234", m_approx(16'h1234, 16'h1111), 17'h02345);
        chk("pin_ap_00ff", m_approx(16'h00FF, 16'h0001), 17'h00000);
        chk("pin_ex_00ff", m_exact(16'h00FF, 16'h0001), 17'h00100);
        chk("pin_ap_ffff", m_approx(16'hFFFF, 16'h0001), 17'h0FF00);
        chk("pin_ex_ffff", m_exact(16'hFFFF, 16'h0001), 17'h10000);

        // Reset values.
        #12;
        chk("rst_res", bus.res_o, 0);
        chk("rst_valid", bus.out_valid_o, 0);
        chk("rst_cnt", err_cnt, 0);
        @(negedge clk); #1 rst_n = 1;
        #1 chk("rst_in_ready", bus.in_ready_o, 1);

        // Mode 0, no error.
        step(1, 16'h1234, 16'h1111, 0, 1, 0);
        idle(1);
        chk("m0_valid", bus.out_valid_o, 1);
        chk("m0_res", bus.res_o, 17'h02345);
        chk("m0_err", bus.err_o, 0);
        chk("m0_cnt", err_cnt, 0);

        // Mode 0, mispredicted carry.
        step(1, 16'h00FF, 16'h0001, 0, 1, 0);
        idle(1);
        chk("m0e_res", bus.res_o, 17'h00000);
        chk("m0e_err", bus.err_o, 1);
        chk("m0e_corr", bus.corr_o, 0);
        chk("m0e_cnt", err_cnt, 1);

        // Mode 1, same operands: one bubble then corrected result.
        step(1, 16'h00FF, 16'h0001, 1, 1, 0);
        idle(1);
        chk("m1_corr_valid", bus.out_valid_o, 0);
        chk("m1_corr_ready", bus.in_ready_o, 0);
        idle(1);
        chk("m1_res", bus.res_o, 17'h00100);
        chk("m1_err", bus.err_o, 1);
        chk("m1_corr", bus.corr_o, 1);

        // Carry out of the top block.
        step(1, 16'hFFFF, 16'h0001, 1, 1, 0);
        idle(1);
        idle(1);
        chk("m1_ffff_res", bus.res_o, 17'h10000);
        chk("m1_ffff_corr", bus.corr_o, 1);
        step(1, 16'hFFFF, 16'h0001, 0, 1, 0);
        idle(1);
        chk("m0_ffff_res", bus.res_o, 17'h0FF00);
        chk("m0_ffff_err", bus.err_o, 1);

        // Backpressure: held result stays stable, no new beat accepted.
        step(1, 16'h2222, 16'h1111, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 16'h0F0F + 16'(i), 16'h0101, 0, 0, 0);
            chk("bp_res", bus.res_o, 17'h03333);
            chk("bp_in_ready", bus.in_ready_o, 0);
        end
        idle(1);
        idle(1);

        // Eight error-free beats back to back.
        n_out = 0;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) step(1, 16'h1000 + 16'(i), 16'h0100, 0, 1, 0);
            else idle(1);
            if (i > 0 && bus.out_valid_o) n_out++;
        end
        chk("stream_8", n_out, 8);

        // Counter saturation, then clear against a simultaneous error beat.
        for (int i = 0; i < CMAX + 5; i++) step(1, 16'h00FF, 16'h0001, 0, 1, 0);
        idle(1);
        chk("cnt_sat", err_cnt, CMAX);
        step(1, 16'h00FF, 16'h0001, 0, 1, 1);
        idle(1);
        chk("cnt_clr", err_cnt, 0);

        // Reset asserted during the correction cycle.
        step(1, 16'h00FF, 16'h0001, 1, 1, 0);
        idle(1);
        chk("rc_in_corr", bus.in_ready_o, 0);
        #1 rst_n = 0;
        #1;
        chk("rc_valid", bus.out_valid_o, 0);
        chk("rc_res", bus.res_o, 0);
        chk("rc_err", bus.err_o, 0);
        chk("rc_corr", bus.corr_o, 0);
        chk("rc_cnt", err_cnt, 0);
        @(negedge clk); #1 rst_n = 1;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                ra = ra & 16'h7777;
                rb = rb & 16'h7777;
            end
            step(($urandom_range(0, 9) < 7), ra, rb, 1'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
        end
        idle(1);
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
